// File: rtl/backprop_layer_sequencer_if.sv
// Handshake and diff-bus bundle between the backprop layer sequencer and its
// neighbours (training FSM on start/done, backprop stack/datapath on steps).
// Optional BACKPROP_STALL_CNT_EN adds the stall_count observation port.
interface backprop_layer_sequencer_if #(
   parameter int unsigned size      = 3,
   parameter int unsigned data_size = 16
);
   localparam int unsigned bus_w = data_size * size;

   logic              start;
   logic              backprop_cost;
   logic              abort;
   logic              step_ready;
   logic [bus_w-1:0]  diff_start;
   logic [bus_w-1:0]  diff_to_all;
   logic [bus_w-1:0]  diff_dense;
   logic [bus_w-1:0]  diff_cost;

   logic              busy;
   logic              done;
   logic              is_update;
   logic              is_cost_layer;
   logic [31:0]       current_layer_index;
   logic [31:0]       dc_dw_layer_index;
   logic [31:0]       w_row_index;
   logic              stack_reset;
   logic              copy;
   logic              cal_dy_dy_old;
   logic [bus_w-1:0]  diff_start_out;
   logic [bus_w-1:0]  diff_to_all_out;
   logic [bus_w-1:0]  diff_dense_out;
`ifdef BACKPROP_STALL_CNT_EN
   logic [31:0]       stall_count;
`endif

   // Controller side: drives requests and diff sources, observes steps.
   modport master (
      output start, backprop_cost, abort, step_ready,
      output diff_start, diff_to_all, diff_dense, diff_cost,
      input  busy, done, is_update, is_cost_layer,
      input  current_layer_index, dc_dw_layer_index, w_row_index,
      input  stack_reset, copy, cal_dy_dy_old,
      input  diff_start_out, diff_to_all_out, diff_dense_out
`ifdef BACKPROP_STALL_CNT_EN
      , input stall_count
`endif
   );

   // Sequencer side.
   modport slave (
      input  start, backprop_cost, abort, step_ready,
      input  diff_start, diff_to_all, diff_dense, diff_cost,
      output busy, done, is_update, is_cost_layer,
      output current_layer_index, dc_dw_layer_index, w_row_index,
      output stack_reset, copy, cal_dy_dy_old,
      output diff_start_out, diff_to_all_out, diff_dense_out
`ifdef BACKPROP_STALL_CNT_EN
      , output stall_count
`endif
   );
endinterface

// File: rtl/backprop_layer_sequencer.sv
// Backprop layer sequencer: walks layers layer_count-1 down to 0, size rows
// each, presenting one registered step per accepted step_ready.
// Optional BACKPROP_STALL_CNT_EN adds a saturating RUN-stall counter.
module backprop_layer_sequencer #(
   parameter int unsigned size        = 3,
   parameter int unsigned data_size   = 16,
   parameter int unsigned layer_count = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   backprop_layer_sequencer_if.slave   bus
);
   localparam int unsigned bus_w     = data_size * size;
   localparam logic [31:0] last_row  = 32'(size - 1);
   localparam logic [31:0] top_layer = 32'(layer_count - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_d;
   logic [31:0]       layer, layer_d;
   logic [31:0]       row, row_d;
   logic              mode, mode_d;
   logic              issue_c;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              is_update_q, is_update_d;
   logic              is_cost_q, is_cost_d;
   logic [31:0]       cur_layer_q, cur_layer_d;
   logic [31:0]       dc_dw_q, dc_dw_d;
   logic [31:0]       w_row_q, w_row_d;
   logic              stack_reset_q, stack_reset_d;
   logic              copy_q, copy_d;
   logic              cal_q, cal_d;
   logic [bus_w-1:0]  dstart_q, dstart_d;
   logic [bus_w-1:0]  dall_q, dall_d;
   logic [bus_w-1:0]  ddense_q, ddense_d;
`ifdef BACKPROP_STALL_CNT_EN
   logic [31:0]       stall_q, stall_d;
`endif

   // Next state, walk counters and the step image presented at the next edge.
   always_comb begin
      state_d       = state;
      layer_d       = layer;
      row_d         = row;
      mode_d        = mode;
      issue_c       = 1'b0;
      is_update_d   = 1'b0;
      is_cost_d     = 1'b0;
      cur_layer_d   = 32'd0;
      dc_dw_d       = 32'd0;
      w_row_d       = 32'd0;
      stack_reset_d = 1'b0;
      copy_d        = 1'b0;
      cal_d         = 1'b0;
      dstart_d      = '0;
      dall_d        = '0;
      ddense_d      = '0;
`ifdef BACKPROP_STALL_CNT_EN
      stall_d       = stall_q;
`endif

      unique case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = RUN;
               layer_d = top_layer;
               row_d   = 32'd0;
               mode_d  = bus.backprop_cost;
`ifdef BACKPROP_STALL_CNT_EN
               stall_d = 32'd0;
`endif
            end
         end
         RUN: begin
`ifdef BACKPROP_STALL_CNT_EN
            if (!bus.step_ready && stall_q != 32'hFFFF_FFFF)
               stall_d = stall_q + 32'd1;
`endif
            if (bus.abort) begin
               state_d = IDLE;
            end else if (bus.step_ready) begin
               issue_c = 1'b1;
               if (row == last_row) begin
                  row_d = 32'd0;
                  if (layer == 32'd0) begin
                     state_d = DONE;
                     layer_d = 32'd0;
                  end else begin
                     layer_d = layer - 32'd1;
                  end
               end else begin
                  row_d = row + 32'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (issue_c) begin
         is_update_d   = 1'b1;
         is_cost_d     = (layer == top_layer);
         cur_layer_d   = layer;
         w_row_d       = row;
         dc_dw_d       = mode ? row : 32'd0;
         stack_reset_d = (row == 32'd0);
         copy_d        = mode && (row == 32'd0);
         cal_d         = (row == last_row);
         if (layer == top_layer) begin
            ddense_d = bus.diff_cost;
         end else begin
            dstart_d = bus.diff_start;
            dall_d   = bus.diff_to_all;
            ddense_d = bus.diff_dense;
         end
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State, counters and registered outputs; reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         layer         <= 32'd0;
         row           <= 32'd0;
         mode          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         is_update_q   <= 1'b0;
         is_cost_q     <= 1'b0;
         cur_layer_q   <= 32'd0;
         dc_dw_q       <= 32'd0;
         w_row_q       <= 32'd0;
         stack_reset_q <= 1'b0;
         copy_q        <= 1'b0;
         cal_q         <= 1'b0;
         dstart_q      <= '0;
         dall_q        <= '0;
         ddense_q      <= '0;
`ifdef BACKPROP_STALL_CNT_EN
         stall_q       <= 32'd0;
`endif
      end else begin
         state         <= state_d;
         layer         <= layer_d;
         row           <= row_d;
         mode          <= mode_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         is_update_q   <= is_update_d;
         is_cost_q     <= is_cost_d;
         cur_layer_q   <= cur_layer_d;
         dc_dw_q       <= dc_dw_d;
         w_row_q       <= w_row_d;
         stack_reset_q <= stack_reset_d;
         copy_q        <= copy_d;
         cal_q         <= cal_d;
         dstart_q      <= dstart_d;
         dall_q        <= dall_d;
         ddense_q      <= ddense_d;
`ifdef BACKPROP_STALL_CNT_EN
         stall_q       <= stall_d;
`endif
      end
   end

   assign bus.busy                = busy_q;
   assign bus.done                = done_q;
   assign bus.is_update           = is_update_q;
   assign bus.is_cost_layer       = is_cost_q;
   assign bus.current_layer_index = cur_layer_q;
   assign bus.dc_dw_layer_index   = dc_dw_q;
   assign bus.w_row_index         = w_row_q;
   assign bus.stack_reset         = stack_reset_q;
   assign bus.copy                = copy_q;
   assign bus.cal_dy_dy_old       = cal_q;
   assign bus.diff_start_out      = dstart_q;
   assign bus.diff_to_all_out     = dall_q;
   assign bus.diff_dense_out      = ddense_q;
`ifdef BACKPROP_STALL_CNT_EN
   assign bus.stall_count         = stall_q;
`endif
endmodule

// File: tb/tb_backprop_layer_sequencer.sv
// Directed bench: main instance layer_count=2, size=3, data_size=16, plus a
// layer_count=1, size=1 corner instance. Inputs driven and outputs sampled
// on the falling edge.
module tb_backprop_layer_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   backprop_layer_sequencer_if #(.size(3), .data_size(16)) bus ();
   backprop_layer_sequencer_if #(.size(1), .data_size(16)) bus1 ();

   backprop_layer_sequencer #(.size(3), .data_size(16), .layer_count(2)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   backprop_layer_sequencer #(.size(1), .data_size(16), .layer_count(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   task automatic init_inputs;
      bus.start = 0; bus.backprop_cost = 0; bus.abort = 0; bus.step_ready = 0;
      bus.diff_start = 48'h333; bus.diff_to_all = 48'h444;
      bus.diff_dense = 48'h222; bus.diff_cost = 48'h111;
      bus1.start = 0; bus1.backprop_cost = 0; bus1.abort = 0; bus1.step_ready = 0;
      bus1.diff_start = 16'h0aaa; bus1.diff_to_all = 16'h0bbb;
      bus1.diff_dense = 16'h0ccc; bus1.diff_cost = 16'h0ddd;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({bus.busy, bus.done, bus.is_update, bus.copy, bus.stack_reset, bus.cal_dy_dy_old, bus.is_cost_layer} !== 7'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 0", {bus.busy, bus.done, bus.is_update, bus.copy, bus.stack_reset, bus.cal_dy_dy_old, bus.is_cost_layer});
      end
      checks++;
      if ({bus.current_layer_index, bus.w_row_index, bus.dc_dw_layer_index} !== 96'b0) begin
         errors++; $display("FAIL reset_indices: layer %0d row %0d dcdw %0d expected 0", bus.current_layer_index, bus.w_row_index, bus.dc_dw_layer_index);
      end
      checks++;
      if ({bus.diff_start_out, bus.diff_to_all_out, bus.diff_dense_out} !== 144'b0) begin
         errors++; $display("FAIL reset_diffs: got %h %h %h expected 0", bus.diff_start_out, bus.diff_to_all_out, bus.diff_dense_out);
      end
      checks++;
      if ({bus1.busy, bus1.done, bus1.is_update} !== 3'b0) begin
         errors++; $display("FAIL reset_corner: got %b expected 000", {bus1.busy, bus1.done, bus1.is_update});
      end
   endtask

   // Full walk with mode=1 and diff gating.
   task automatic test_full_walk;
      logic [31:0] exp_layer [6] = '{1, 1, 1, 0, 0, 0};
      logic [31:0] exp_row   [6] = '{0, 1, 2, 0, 1, 2};
      // {is_update, stack_reset, copy, cal_dy_dy_old, is_cost_layer, done}
      logic [5:0]  exp_flags [6] = '{6'b111010, 6'b100010, 6'b100110,
                                     6'b111000, 6'b100000, 6'b100101};
      logic [47:0] exp_dense [6] = '{48'h111, 48'h111, 48'h111, 48'h222, 48'h222, 48'h222};
      logic [47:0] exp_start [6] = '{48'h0, 48'h0, 48'h0, 48'h333, 48'h333, 48'h333};
      logic [47:0] exp_all   [6] = '{48'h0, 48'h0, 48'h0, 48'h444, 48'h444, 48'h444};
      bus.start = 1; bus.backprop_cost = 1; bus.step_ready = 1;
      @(negedge clk);
      bus.start = 0;
      checks++;
      if ({bus.busy, bus.is_update} !== 2'b10) begin
         errors++; $display("FAIL walk_first_cycle: busy,is_update %b expected 10", {bus.busy, bus.is_update});
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.is_update, bus.stack_reset, bus.copy, bus.cal_dy_dy_old, bus.is_cost_layer, bus.done} !== exp_flags[i]) begin
            errors++; $display("FAIL walk_flags step %0d: got %b expected %b", i + 1, {bus.is_update, bus.stack_reset, bus.copy, bus.cal_dy_dy_old, bus.is_cost_layer, bus.done}, exp_flags[i]);
         end
         checks++;
         if (bus.current_layer_index !== exp_layer[i] || bus.w_row_index !== exp_row[i] || bus.dc_dw_layer_index !== exp_row[i]) begin
            errors++; $display("FAIL walk_index step %0d: layer %0d row %0d dcdw %0d expected %0d %0d %0d", i + 1, bus.current_layer_index, bus.w_row_index, bus.dc_dw_layer_index, exp_layer[i], exp_row[i], exp_row[i]);
         end
         checks++;
         if (bus.diff_dense_out !== exp_dense[i] || bus.diff_start_out !== exp_start[i] || bus.diff_to_all_out !== exp_all[i]) begin
            errors++; $display("FAIL walk_diff step %0d: dense %h start %h all %h expected %h %h %h", i + 1, bus.diff_dense_out, bus.diff_start_out, bus.diff_to_all_out, exp_dense[i], exp_start[i], exp_all[i]);
         end
      end
      @(negedge clk);
      bus.step_ready = 0; bus.backprop_cost = 0;
      checks++;
      if ({bus.busy, bus.done, bus.is_update} !== 3'b000) begin
         errors++; $display("FAIL walk_after_done: busy,done,is_update %b expected 000", {bus.busy, bus.done, bus.is_update});
      end
   endtask

   // Mode latched at start; toggling mid-walk must not enable copy.
   task automatic test_mode_latch;
      bus.start = 1; bus.backprop_cost = 0; bus.step_ready = 1;
      @(negedge clk);
      bus.start = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) bus.backprop_cost = 1;
         checks++;
         if ({bus.is_update, bus.copy, bus.stack_reset} !== {1'b1, 1'b0, (i % 3) == 0} || bus.dc_dw_layer_index !== 32'd0) begin
            errors++; $display("FAIL mode_latch step %0d: upd,copy,sr %b dcdw %0d expected %b 0", i + 1, {bus.is_update, bus.copy, bus.stack_reset}, bus.dc_dw_layer_index, {1'b1, 1'b0, (i % 3) == 0});
         end
      end
      @(negedge clk);
      bus.step_ready = 0; bus.backprop_cost = 0;
   endtask

   // Three stall cycles after step 2.
   task automatic test_stall;
      logic [31:0] exp_layer [4] = '{1, 0, 0, 0};
      logic [31:0] exp_row   [4] = '{2, 0, 1, 2};
      bus.start = 1; bus.backprop_cost = 1; bus.step_ready = 1;
      @(negedge clk);
      bus.start = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.is_update !== 1'b1 || bus.w_row_index !== 32'd1) begin
         errors++; $display("FAIL stall_step2: is_update %b row %0d expected 1 1", bus.is_update, bus.w_row_index);
      end
      bus.step_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) bus.step_ready = 1;
         checks++;
         if ({bus.is_update, bus.busy} !== 2'b01 || bus.w_row_index !== 32'd0) begin
            errors++; $display("FAIL stall_gap %0d: is_update,busy %b row %0d expected 01 0", i, {bus.is_update, bus.busy}, bus.w_row_index);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.is_update !== 1'b1 || bus.current_layer_index !== exp_layer[i] || bus.w_row_index !== exp_row[i] || bus.done !== (i == 3)) begin
            errors++; $display("FAIL stall_resume step %0d: upd %b layer %0d row %0d done %b expected 1 %0d %0d %b", i + 3, bus.is_update, bus.current_layer_index, bus.w_row_index, bus.done, exp_layer[i], exp_row[i], i == 3);
         end
      end
`ifdef BACKPROP_STALL_CNT_EN
      checks++;
      if (bus.stall_count !== 32'd3) begin
         errors++; $display("FAIL stall_count: got %0d expected 3", bus.stall_count);
      end
`endif
      @(negedge clk);
      bus.step_ready = 0;
   endtask

   // Abort at step 4, then restart from the cost layer.
   task automatic test_abort;
      bus.start = 1; bus.backprop_cost = 1; bus.step_ready = 1;
      @(negedge clk);
      bus.start = 0;
      repeat (3) @(negedge clk);
      bus.abort = 1;
      @(negedge clk);
      bus.abort = 0;
      checks++;
      if ({bus.busy, bus.done, bus.is_update} !== 3'b000 || bus.current_layer_index !== 32'd0) begin
         errors++; $display("FAIL abort_idle: busy,done,upd %b layer %0d expected 000 0", {bus.busy, bus.done, bus.is_update}, bus.current_layer_index);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         errors++; $display("FAIL abort_no_done: busy,done %b expected 00", {bus.busy, bus.done});
      end
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      @(negedge clk);
      checks++;
      if ({bus.is_update, bus.is_cost_layer, bus.copy} !== 3'b111 || bus.current_layer_index !== 32'd1 || bus.w_row_index !== 32'd0) begin
         errors++; $display("FAIL abort_restart: upd,cost,copy %b layer %0d row %0d expected 111 1 0", {bus.is_update, bus.is_cost_layer, bus.copy}, bus.current_layer_index, bus.w_row_index);
      end
      bus.abort = 1;
      @(negedge clk);
      bus.abort = 0; bus.step_ready = 0;
   endtask

   // Synchronous reset mid-walk clears all outputs at the next edge.
   task automatic test_reset_mid_walk;
      bus.start = 1; bus.backprop_cost = 1; bus.step_ready = 1;
      @(negedge clk);
      bus.start = 0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.is_update !== 1'b1 || bus.diff_dense_out !== 48'h222) begin
         errors++; $display("FAIL reset_mid_pre: upd %b dense %h expected 1 222", bus.is_update, bus.diff_dense_out);
      end
      reset = 1;
      @(negedge clk);
      reset = 0; bus.step_ready = 0;
      checks++;
      if ({bus.busy, bus.done, bus.is_update, bus.copy, bus.stack_reset, bus.cal_dy_dy_old, bus.is_cost_layer} !== 7'b0 ||
          {bus.current_layer_index, bus.w_row_index, bus.dc_dw_layer_index} !== 96'b0 ||
          {bus.diff_start_out, bus.diff_to_all_out, bus.diff_dense_out} !== 144'b0) begin
         errors++; $display("FAIL reset_mid_clear: flags %b layer %0d row %0d dense %h expected all 0", {bus.busy, bus.done, bus.is_update, bus.copy, bus.stack_reset, bus.cal_dy_dy_old, bus.is_cost_layer}, bus.current_layer_index, bus.w_row_index, bus.diff_dense_out);
      end
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         errors++; $display("FAIL reset_mid_no_done: busy,done %b expected 00", {bus.busy, bus.done});
      end
   endtask

   // layer_count=1, size=1: single step carrying every row/layer strobe plus done.
   task automatic test_single_step;
      bus1.start = 1; bus1.backprop_cost = 1; bus1.step_ready = 1;
      @(negedge clk);
      bus1.start = 0;
      @(negedge clk);
      checks++;
      if ({bus1.is_update, bus1.stack_reset, bus1.cal_dy_dy_old, bus1.is_cost_layer, bus1.done, bus1.busy, bus1.copy} !== 7'b1111111) begin
         errors++; $display("FAIL single_flags: got %b expected 1111111", {bus1.is_update, bus1.stack_reset, bus1.cal_dy_dy_old, bus1.is_cost_layer, bus1.done, bus1.busy, bus1.copy});
      end
      checks++;
      if (bus1.diff_dense_out !== 16'h0ddd || bus1.diff_start_out !== 16'h0 || bus1.current_layer_index !== 32'd0) begin
         errors++; $display("FAIL single_data: dense %h start %h layer %0d expected 0ddd 0 0", bus1.diff_dense_out, bus1.diff_start_out, bus1.current_layer_index);
      end
      @(negedge clk);
      bus1.step_ready = 0;
      checks++;
      if ({bus1.busy, bus1.done, bus1.is_update} !== 3'b000) begin
         errors++; $display("FAIL single_after: busy,done,upd %b expected 000", {bus1.busy, bus1.done, bus1.is_update});
      end
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_full_walk();
      test_mode_latch();
      test_stall();
      test_abort();
      test_reset_mid_walk();
      test_single_step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
